// File: rtl/peripheral_port_arbiter.sv
// Round-robin arbiter sharing the peripheral core register port between N_REQ requesters.
// Optional grant locking for atomic sequences is compiled in with PERIPH_ARB_LOCK_EN.
module peripheral_port_arbiter #(
   parameter int N_REQ        = 4,
   parameter int ADDR_W       = 27,
   parameter int DATA_W       = 32,
   parameter int LOCK_TIMEOUT = 16
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic [N_REQ-1:0]         req_i,
   input  logic [N_REQ-1:0]         rw_i,
   input  logic [N_REQ*ADDR_W-1:0]  add_i,
   input  logic [N_REQ*DATA_W-1:0]  wdata_i,
   input  logic [N_REQ-1:0]         lock_i,
   output logic [N_REQ*DATA_W-1:0]  rdata_o,
   output logic [N_REQ-1:0]         ack_o,
   output logic [N_REQ-1:0]         grant_o,
   output logic                     busy_o,
   output logic                     per_req_o,
   output logic                     per_rw_o,
   output logic [ADDR_W-1:0]        per_add_o,
   output logic [DATA_W-1:0]        per_data_o,
   input  logic [DATA_W-1:0]        per_data_i
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef PERIPH_ARB_LOCK_EN
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);
   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_ACK, S_LOCKED
   } state_t;
   logic [TW-1:0] tmo_q;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_ACK
   } state_t;
   logic unused_lock;
   assign unused_lock = (^lock_i) ^ (LOCK_TIMEOUT > 0);
`endif

   state_t                  state_q;
   logic [IW-1:0]           last_q;
   logic [IW-1:0]           win_q;
   logic [N_REQ-1:0]        grant_q;
   logic [N_REQ-1:0]        ack_q;
   logic                    busy_q;
   logic                    per_req_q;
   logic                    per_rw_q;
   logic [ADDR_W-1:0]       per_add_q;
   logic [DATA_W-1:0]       per_data_q;
   logic [N_REQ*DATA_W-1:0] rdata_q;

   logic [IW-1:0]     idx;
   logic [IW-1:0]     win_d;
   logic              hit_d;
   logic [IW-1:0]     sel_d;
   logic [N_REQ-1:0]  oh_d;
   logic              sel_rw;
   logic [ADDR_W-1:0] sel_add;
   logic [DATA_W-1:0] sel_wd;
   logic              start_d;
   logic              lock_w;
   logic              req_w;

   // Scan last+1, last+2, ... wrapping at N_REQ; first hit wins.
   always_comb begin
      idx   = last_q;
      win_d = last_q;
      hit_d = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (idx == IW'(N_REQ - 1)) ? '0 : idx + IW'(1);
         if (!hit_d && req_i[idx]) begin
            hit_d = 1'b1;
            win_d = idx;
         end
      end
   end

   assign lock_w = |(lock_i & grant_q);
   assign req_w  = |(req_i & grant_q);
   assign sel_d  = (state_q == S_IDLE) ? win_d : win_q;

`ifdef PERIPH_ARB_LOCK_EN
   assign start_d = ((state_q == S_IDLE) && hit_d) ||
                    ((state_q == S_LOCKED) && lock_w && req_w);
`else
   assign start_d = (state_q == S_IDLE) && hit_d;
`endif

   always_comb begin
      oh_d    = '0;
      sel_rw  = 1'b0;
      sel_add = '0;
      sel_wd  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (sel_d == IW'(k)) begin
            oh_d[k] = 1'b1;
            sel_rw  = rw_i[k];
            sel_add = add_i[k*ADDR_W +: ADDR_W];
            sel_wd  = wdata_i[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= S_IDLE;
         last_q     <= IW'(N_REQ - 1);
         win_q      <= '0;
         grant_q    <= '0;
         ack_q      <= '0;
         busy_q     <= 1'b0;
         per_req_q  <= 1'b0;
         per_rw_q   <= 1'b0;
         per_add_q  <= '0;
         per_data_q <= '0;
         rdata_q    <= '0;
`ifdef PERIPH_ARB_LOCK_EN
         tmo_q      <= '0;
`endif
      end else begin
         per_req_q <= 1'b0;
         ack_q     <= '0;
         unique case (state_q)
            S_IDLE: begin
               if (hit_d) last_q <= win_d;
            end
            S_ISSUE: state_q <= S_WAIT;
            S_WAIT: begin
               if (!per_rw_q) begin
                  for (int k = 0; k < N_REQ; k++) begin
                     if (win_q == IW'(k))
                        rdata_q[k*DATA_W +: DATA_W] <= per_data_i;
                  end
               end
               ack_q   <= grant_q;
               state_q <= S_ACK;
            end
            S_ACK: begin
`ifdef PERIPH_ARB_LOCK_EN
               if (lock_w) begin
                  state_q <= S_LOCKED;
                  tmo_q   <= '0;
               end else begin
                  state_q <= S_IDLE;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
               end
`else
               state_q <= S_IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
`endif
            end
`ifdef PERIPH_ARB_LOCK_EN
            S_LOCKED: begin
               if (!lock_w || (!req_w && tmo_q == TW'(LOCK_TIMEOUT - 1))) begin
                  state_q <= S_IDLE;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
               end else if (!req_w) begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
`endif
            default: state_q <= S_IDLE;
         endcase
         // A new transaction overrides the per-state updates above.
         if (start_d) begin
            state_q    <= S_ISSUE;
            win_q      <= sel_d;
            grant_q    <= oh_d;
            busy_q     <= 1'b1;
            per_req_q  <= 1'b1;
            per_rw_q   <= sel_rw;
            per_add_q  <= sel_add;
            per_data_q <= sel_wd;
         end
      end
   end

   assign rdata_o    = rdata_q;
   assign ack_o      = ack_q;
   assign grant_o    = grant_q;
   assign busy_o     = busy_q;
   assign per_req_o  = per_req_q;
   assign per_rw_o   = per_rw_q;
   assign per_add_o  = per_add_q;
   assign per_data_o = per_data_q;

endmodule

// File: tb/tb_peripheral_port_arbiter.sv
// Directed bench for peripheral_port_arbiter: vector table plus
// round-robin, held-request, reset-abort and optional lock sequences.
module tb_peripheral_port_arbiter;

   localparam int N  = 4;
   localparam int AW = 27;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req, rw, lock;
   logic [N*AW-1:0] add;
   logic [N*DW-1:0] wdata, rdata;
   logic [N-1:0]    ack, grant;
   logic            busy, per_req, per_rw;
   logic [AW-1:0]   per_add;
   logic [DW-1:0]   per_wd, per_rd, rd_val;

   peripheral_port_arbiter #(
      .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LOCK_TIMEOUT(16)
   ) dut (
      .clock_i(clk), .reset_i(rst_n), .req_i(req), .rw_i(rw),
      .add_i(add), .wdata_i(wdata), .lock_i(lock), .rdata_o(rdata),
      .ack_o(ack), .grant_o(grant), .busy_o(busy), .per_req_o(per_req),
      .per_rw_o(per_rw), .per_add_o(per_add), .per_data_o(per_wd),
      .per_data_i(per_rd)
   );

   always #5 clk = ~clk;

   // Registered peripheral: read data valid only the cycle after the request.
   always @(posedge clk)
      per_rd <= (per_req && !per_rw) ? rd_val : 32'hDEAD_BEEF;

   int nvec = 0;
   int nerr = 0;
   logic [DW-1:0]  model [N];
   logic [N-1:0]   gq[$];
   int             tq[$];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [N*DW-1:0] mbus();
      logic [N*DW-1:0] r;
      for (int k = 0; k < N; k++) r[k*DW +: DW] = model[k];
      return r;
   endfunction

   typedef struct {
      int          who;
      logic        rw;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      logic [DW-1:0] rv;
      logic [DW-1:0] exp_rd;
   } vec_t;
   vec_t tbl [6];

   task automatic run_vec(input vec_t v);
      logic [N-1:0] oh;
      oh = '0;
      oh[v.who] = 1'b1;
      @(negedge clk);
      req = '0;
      req[v.who] = 1'b1;
      rw[v.who] = v.rw;
      add[v.who*AW +: AW] = v.a;
      wdata[v.who*DW +: DW] = v.wd;
      rd_val = v.rv;
      @(negedge clk);
      chk("v.per_req_t1", 128'(per_req), 128'(1'b1));
      chk("v.grant", 128'(grant), 128'(oh));
      chk("v.busy", 128'(busy), 128'(1'b1));
      chk("v.per_rw", 128'(per_rw), 128'(v.rw));
      chk("v.per_add", 128'(per_add), 128'(v.a));
      chk("v.per_data", 128'(per_wd), 128'(v.wd));
      @(negedge clk);
      chk("v.per_req_t2", 128'(per_req), 128'(1'b0));
      chk("v.ack_t2", 128'(ack), 128'(0));
      @(negedge clk);
      chk("v.ack_t3", 128'(ack), 128'(oh));
      req[v.who] = 1'b0;
      model[v.who] = v.exp_rd;
      chk("v.rdata", 128'(rdata), 128'(mbus()));
      @(negedge clk);
      chk("v.ack_t4", 128'(ack), 128'(0));
      chk("v.grant_idle", 128'(grant), 128'(0));
      chk("v.busy_idle", 128'(busy), 128'(1'b0));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req = '0;
      lock = '0;
      for (int k = 0; k < N; k++) model[k] = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drop each requester on its ack; log grants at each peripheral pulse.
   task automatic drain(input int maxc);
      int c;
      c = 0;
      while (c < maxc && !(req == '0 && !busy)) begin
         @(negedge clk);
         if (per_req) begin
            gq.push_back(grant);
            tq.push_back(c);
         end
         req = req & ~ack;
         c++;
      end
      chk("drain_done", 128'(busy), 128'(1'b0));
   endtask

`ifdef PERIPH_ARB_LOCK_EN
   task automatic lock_seq(input int dly, input logic [N-1:0] e0,
                           input logic [N-1:0] e1, input logic [N-1:0] e2);
      int n0, tre, ta;
      n0 = 0; tre = -1; ta = -1;
      gq.delete();
      @(negedge clk);
      rw[0] = 1'b0; rw[1] = 1'b1;
      req = 4'b0011; lock = 4'b0001;
      rd_val = 32'hD00D_0004;
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         if (per_req) gq.push_back(grant);
         if (c == ta + 1) chk("lk.grant_held", 128'(grant), 128'(4'b0001));
         if (ack[0]) begin
            n0++;
            req[0] = 1'b0;
            if (n0 == 1) begin
               tre = c + dly;
               ta = c;
               model[0] = 32'hD00D_0004;
            end else lock[0] = 1'b0;
         end
         if (ack[1]) req[1] = 1'b0;
         if (c == tre) begin
            req[0] = 1'b1;
            rw[0] = 1'b1;
         end
         if (req == '0 && !busy && gq.size() == 3) break;
      end
      chk("lk.count", 128'(gq.size()), 128'(3));
      if (gq.size() == 3) begin
         chk("lk.g0", 128'(gq[0]), 128'(e0));
         chk("lk.g1", 128'(gq[1]), 128'(e1));
         chk("lk.g2", 128'(gq[2]), 128'(e2));
      end
      chk("lk.rdata", 128'(rdata), 128'(mbus()));
      lock = '0;
   endtask
`endif

   initial begin
      tbl[0] = '{0, 1'b0, 27'h000_0123, 32'h0,         32'hA5A5_0001, 32'hA5A5_0001};
      tbl[1] = '{1, 1'b1, 27'h7FF_FFFF, 32'h1111_2222, 32'h0,         32'h0};
      tbl[2] = '{2, 1'b0, 27'h000_0000, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF};
      tbl[3] = '{3, 1'b0, 27'h400_0000, 32'h0,         32'h5A5A_5A5A, 32'h5A5A_5A5A};
      tbl[4] = '{0, 1'b1, 27'h000_0010, 32'hCAFE_F00D, 32'h0,         32'hA5A5_0001};
      tbl[5] = '{1, 1'b0, 27'h000_0020, 32'h0,         32'h1234_5678, 32'h1234_5678};

      rst_n = 1'b0;
      req = '0; rw = '0; lock = '0; add = '0; wdata = '0; rd_val = '0;
      for (int k = 0; k < N; k++) model[k] = '0;
      repeat (2) @(negedge clk);
      chk("rst.per_req", 128'(per_req), 128'(0));
      chk("rst.per_rw", 128'(per_rw), 128'(0));
      chk("rst.per_add", 128'(per_add), 128'(0));
      chk("rst.per_data", 128'(per_wd), 128'(0));
      chk("rst.ack", 128'(ack), 128'(0));
      chk("rst.grant", 128'(grant), 128'(0));
      chk("rst.busy", 128'(busy), 128'(0));
      chk("rst.rdata", 128'(rdata), 128'(0));
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(tbl[i]);

      // All four write together from reset: served 0,1,2,3, four cycles apart.
      do_reset();
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         add[k*AW +: AW] = AW'(k * 256);
         wdata[k*DW +: DW] = 32'h1000_0000 + DW'(k);
      end
      rw = 4'b1111;
      req = 4'b1111;
      gq.delete(); tq.delete();
      drain(60);
      chk("rr.count", 128'(gq.size()), 128'(4));
      if (gq.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("rr.order", 128'(gq[i]), 128'(4'(1) << i));
            if (i > 0) chk("rr.spacing", 128'(tq[i] - tq[i-1]), 128'(4));
         end
      end
      chk("rr.rdata", 128'(rdata), 128'(mbus()));

      // Requester 2 holds req across its ack while 1 waits: 2,1,2.
      begin
         int n2;
         n2 = 0;
         gq.delete();
         @(negedge clk);
         rw[2] = 1'b0;
         rd_val = 32'hBBBB_0002;
         req = 4'b0100;
         for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (per_req) gq.push_back(grant);
            if (grant == 4'b0100 && gq.size() == 1) req[1] = 1'b1;
            if (ack[1]) req[1] = 1'b0;
            if (ack[2]) begin
               n2++;
               if (n2 == 2) req[2] = 1'b0;
            end
            if (req == '0 && !busy) break;
         end
         model[2] = 32'hBBBB_0002;
         chk("hold.count", 128'(gq.size()), 128'(3));
         if (gq.size() == 3) begin
            chk("hold.g0", 128'(gq[0]), 128'(4'b0100));
            chk("hold.g1", 128'(gq[1]), 128'(4'b0010));
            chk("hold.g2", 128'(gq[2]), 128'(4'b0100));
         end
         chk("hold.rdata", 128'(rdata), 128'(mbus()));
      end

      // Reset during WAIT of a read aborts it; pointer restarts at 0.
      @(negedge clk);
      add[2*AW +: AW] = 27'h000_0003;
      rw[2] = 1'b0;
      rd_val = 32'hCCCC_0003;
      req = 4'b0100;
      @(negedge clk);
      chk("ra.issue", 128'(per_req), 128'(1'b1));
      @(negedge clk);
      chk("ra.wait", 128'({busy, per_req}), 128'(2'b10));
      rst_n = 1'b0;
      #1;
      chk("ra.outs", 128'({per_req, per_rw, per_add, per_wd, ack, grant, busy}), 128'(0));
      chk("ra.rdata", 128'(rdata), 128'(0));
      for (int k = 0; k < N; k++) model[k] = '0;
      req = '0;
      repeat (2) begin
         @(negedge clk);
         chk("ra.noack", 128'(ack), 128'(0));
      end
      rst_n = 1'b1;
      rw = 4'b1111;
      req = 4'b1001;
      @(negedge clk);
      chk("ra.first", 128'(grant), 128'(4'b0001));
      gq.delete(); tq.delete();
      gq.push_back(grant);
      drain(40);
      chk("ra.count", 128'(gq.size()), 128'(2));
      if (gq.size() == 2) chk("ra.second", 128'(gq[1]), 128'(4'b1000));

`ifdef PERIPH_ARB_LOCK_EN
      lock_seq(2,  4'b0001, 4'b0001, 4'b0010);
      lock_seq(17, 4'b0001, 4'b0010, 4'b0001);
`endif

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/peripheral_port_arbiter.md
Name: peripheral_port_arbiter

Overview:
- Shares the single core-side register port of the peripheral system between N_REQ requesters (cores, DMA, sampler readback) using round-robin arbitration.
- Sequences each access as one single-cycle request pulse to the peripheral. The peripheral's registered read data arrives one cycle later; the arbiter captures it and returns it to the winning requester with a one-cycle ack.
- Sits between the requester interconnect and the peripheral's req/rw/add/data core port. The control-system port is untouched.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- ADDR_W, 27, peripheral address width.
- DATA_W, 32, data width.
- LOCK_TIMEOUT, 16, cycles a locked grant is held while waiting for the owner's next req. Used only with the optional feature.

Ports:
- clock_i  in  1  system clock; all logic on posedge.
- reset_i  in  1  asynchronous, active-low reset.
- req_i  in  N_REQ  per-requester request level; held until the matching ack_o.
- rw_i  in  N_REQ  per-requester direction; 1 = write, 0 = read.
- add_i  in  N_REQ*ADDR_W  flattened addresses; requester k at [k*ADDR_W +: ADDR_W].
- wdata_i  in  N_REQ*DATA_W  flattened write data.
- lock_i  in  N_REQ  keep-grant request; ignored unless the optional feature is compiled in.
- rdata_o  out  N_REQ*DATA_W  per-requester read data, registered.
- ack_o  out  N_REQ  one-cycle completion pulse, one-hot.
- grant_o  out  N_REQ  one-hot owner of the current transaction; 0 in IDLE.
- busy_o  out  1  high in any state other than IDLE.
- per_req_o  out  1  request to peripheral; exactly one cycle per transaction.
- per_rw_o  out  1  direction to peripheral.
- per_add_o  out  ADDR_W  address to peripheral.
- per_data_o  out  DATA_W  write data to peripheral.
- per_data_i  in  DATA_W  peripheral read data; valid the cycle after per_req_o.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - state=IDLE.
  - per_req_o=0, per_rw_o=0, per_add_o=0, per_data_o=0.
  - ack_o=0, grant_o=0, busy_o=0, all rdata_o=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 wins first.
  - Reset mid-transaction aborts it: no ack is issued, and a partially issued write is not replayed.
- FSM states: IDLE -> ISSUE -> WAIT -> ACK -> IDLE. All outputs are registered.
- IDLE:
  - If any req_i is high, select the first requester with req high scanning last+1, last+2, ... modulo N_REQ.
  - Latch its rw/add/wdata into per_* registers, set grant_o, set last=winner, go to ISSUE.
- ISSUE: per_req_o=1 for this cycle only. Go to WAIT.
- WAIT:
  - per_req_o=0.
  - If the transaction is a read, capture per_data_i into rdata_o[winner].
  - Go to ACK.
- ACK: ack_o[winner]=1 for one cycle. Go to IDLE; grant_o clears on entering IDLE.
- Latency: req_i seen high in cycle t (arbiter in IDLE) -> per_req_o in t+1 -> ack_o in t+3. Back-to-back transactions take 4 cycles each.
- req_i is sampled only in IDLE. Consequences:
  - A requester must deassert req the cycle after its ack, or it is re-arbitrated as a new transaction.
  - A req dropped during ISSUE/WAIT/ACK does not cancel; the ack is still issued.
- rdata_o[k] holds its value until the next read completed for k.
- Writes never modify rdata_o.
- Reads of unmapped addresses return whatever per_data_i presents; the arbiter does not decode addresses.
- Simultaneous requests are resolved by round-robin only. No requester waits more than N_REQ-1 transactions.

Optional Feature:
- Macro: PERIPH_ARB_LOCK_EN.
- Enabled:
  - If lock_i[winner]=1 during ACK, the arbiter enters LOCKED instead of IDLE; grant_o stays on the winner.
  - In LOCKED, only req_i[winner] is considered. If it is high, start the next transaction (-> ISSUE) without updating last.
  - Leave LOCKED for IDLE when lock_i[winner] drops or when LOCK_TIMEOUT cycles elapse with no req. The counter resets on each locked transaction.
  - Supports atomic read-modify-write of comm registers.
- Disabled: lock_i is unused, no LOCKED state, no timeout counter.

Test Plan:
- Single read: req0 reads addr X where the peripheral returns 0xA5A5_0001 -> per_req_o is one pulse at t+1, ack_o=4'b0001 at t+3, rdata_o[0]=0xA5A5_0001; other rdata_o stay 0.
- All four requesters write from reset, each dropping req after its own ack -> grant order 0,1,2,3; four per_req_o pulses 4 cycles apart; per_data_o matches each wdata; no rdata_o changes.
- Requester 2 holds req across its ack (does not drop) while req1 is also high -> 1 is served next, then 2 again; no back-to-back grant to 2.
- Assert reset_i=0 during WAIT of a read -> all outputs 0 immediately, no ack_o; after release, the first grant goes to requester 0.
- With PERIPH_ARB_LOCK_EN: req0 read with lock, then write within 5 cycles while req1 is pending -> requester 0 is served twice before 1. Repeat with the 2nd req delayed 17 cycles -> LOCKED times out and requester 1 is served first.
